// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: run controller and result checker wrapped around the CPU.
// Sequences the CPU reset, counts RUN cycles, detects halt as a stalled PC,
// enforces a cycle watchdog and compares result registers against expected.
module cpu_run_monitor #(
  parameter int DATA_WIDTH     = 32,
  parameter int CHK_CH         = 2,
  parameter int RESET_CYCLES   = 2,
  parameter int HALT_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Start,
  input  logic [DATA_WIDTH-1:0]        PC_out,
  input  logic [CHK_CH*DATA_WIDTH-1:0] Readv_bus,
  input  logic [CHK_CH*DATA_WIDTH-1:0] Expected_bus,
  input  logic [CHK_CH-1:0]            Check_mask,
  output logic                         CPU_Reset,
  output logic                         Halted,
  output logic                         Timeout,
  output logic                         Done,
  output logic                         Pass,
  output logic [CHK_CH-1:0]            Mismatch_mask,
  output logic [CNT_WIDTH-1:0]         CycleCount
);

  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam int SW = $clog2(HALT_CYCLES + 1);
  localparam logic [HW-1:0]        HOLD_LAST   = HW'(RESET_CYCLES);
  localparam logic [SW-1:0]        STABLE_LAST = SW'(HALT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_COUNT   = CNT_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_HOLD, S_RUN, S_CHECK, S_DONE} state_t;

  state_t                state;
  logic [HW-1:0]         hold_cnt;
  logic [SW-1:0]         stable_cnt;
  logic [DATA_WIDTH-1:0] pc_prev;
  logic                  prev_valid;

  logic [CNT_WIDTH-1:0]  cnt_next;
  logic [SW-1:0]         stable_inc;
  logic                  pc_same;
  logic                  halt_now;
  logic                  tmo_now;
  logic [CHK_CH-1:0]     mismatch_now;

  // Saturating increments and per-cycle halt/watchdog conditions
  always_comb begin
    cnt_next   = (CycleCount == '1) ? CycleCount : CycleCount + CNT_WIDTH'(1);
    stable_inc = (stable_cnt == '1) ? stable_cnt : stable_cnt + SW'(1);
    pc_same    = prev_valid && (PC_out == pc_prev);
    halt_now   = (stable_cnt == STABLE_LAST);
    tmo_now    = (cnt_next == TMO_COUNT);
  end

  // Per-channel compare of result registers, gated by the check mask
  always_comb begin
    mismatch_now = '0;
    for (int i = 0; i < CHK_CH; i++)
      mismatch_now[i] = Check_mask[i] &&
        (Readv_bus[i*DATA_WIDTH +: DATA_WIDTH] != Expected_bus[i*DATA_WIDTH +: DATA_WIDTH]);
  end

  // Run-control FSM; all outputs are registered here
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= S_HOLD;
      hold_cnt      <= '0;
      stable_cnt    <= '0;
      pc_prev       <= '0;
      prev_valid    <= 1'b0;
      CPU_Reset     <= 1'b1;
      Halted        <= 1'b0;
      Timeout       <= 1'b0;
      Done          <= 1'b0;
      Pass          <= 1'b0;
      Mismatch_mask <= '0;
      CycleCount    <= '0;
    end else begin
      case (state)
        S_HOLD: begin
          CPU_Reset <= 1'b1;
          if (hold_cnt == HOLD_LAST) begin
            state     <= S_RUN;
            hold_cnt  <= '0;
            CPU_Reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        S_RUN: begin
          CycleCount <= cnt_next;
          pc_prev    <= PC_out;
          prev_valid <= 1'b1;
          stable_cnt <= pc_same ? stable_inc : '0;
          // Halt takes priority when both fire on the same cycle
          if (halt_now) begin
            Halted <= 1'b1;
            state  <= S_CHECK;
          end else if (tmo_now) begin
            Timeout <= 1'b1;
            state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          // CPU still out of reset here so the result registers are live
          Mismatch_mask <= mismatch_now;
          Pass          <= Halted & ~|mismatch_now;
          Done          <= 1'b1;
          CPU_Reset     <= 1'b1;
          state         <= S_DONE;
        end
        S_DONE: begin
          CPU_Reset <= 1'b1;
          if (Start) begin
            state         <= S_HOLD;
            hold_cnt      <= '0;
            stable_cnt    <= '0;
            prev_valid    <= 1'b0;
            Halted        <= 1'b0;
            Timeout       <= 1'b0;
            Done          <= 1'b0;
            Pass          <= 1'b0;
            Mismatch_mask <= '0;
            CycleCount    <= '0;
          end
        end
        default: state <= S_HOLD;
      endcase
    end
  end

endmodule
